// File: rtl/fmul_axis_issuer.sv
// fmul_axis_issuer: issues operand pairs to an AXI-Stream multiplier and returns tagged, framed results under a credit limit
module fmul_axis_issuer #(
  parameter int TAG_W     = 8,
  parameter int DEPTH     = 16,
  parameter int FRAME_LEN = 64
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_a,
  input  logic [31:0]                in_b,
  input  logic [TAG_W-1:0]           in_tag,
  output logic                       m_axis_a_tvalid,
  input  logic                       m_axis_a_tready,
  output logic [31:0]                m_axis_a_tdata,
  output logic                       m_axis_b_tvalid,
  input  logic                       m_axis_b_tready,
  output logic [31:0]                m_axis_b_tdata,
  input  logic                       s_axis_result_tvalid,
  output logic                       s_axis_result_tready,
  input  logic [31:0]                s_axis_result_tdata,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_data,
  output logic [TAG_W-1:0]           out_tag,
  output logic                       out_last,
  output logic [$clog2(DEPTH+1)-1:0] outstanding,
  output logic                       err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int FW = FRAME_LEN > 1 ? $clog2(FRAME_LEN) : 1;
  localparam logic [FW-1:0] FRAME_END = FW'(FRAME_LEN - 1);
  logic             a_pend, b_pend, ov, ol, err_q;
  logic [31:0]      a_q, b_q, od;
  logic [TAG_W-1:0] ot;
  logic [TAG_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wp, rp;
  logic [CW-1:0]    cnt, out_cnt;
  logic [FW-1:0]    frame_cnt;
  logic             a_fire, b_fire, res_fire, acc, dlv, pop;
  assign m_axis_a_tvalid      = a_pend & ~areset;
  assign m_axis_b_tvalid      = b_pend & ~areset;
  assign m_axis_a_tdata       = areset ? '0 : a_q;
  assign m_axis_b_tdata       = areset ? '0 : b_q;
  assign a_fire               = m_axis_a_tvalid & m_axis_a_tready;
  assign b_fire               = m_axis_b_tvalid & m_axis_b_tready;
  assign in_ready             = ~areset & ~(a_pend & ~a_fire) & ~(b_pend & ~b_fire) & (out_cnt < CW'(DEPTH));
  assign acc                  = in_valid & in_ready;
  assign out_valid            = ov & ~areset;
  assign out_data             = areset ? '0 : od;
  assign out_tag              = areset ? '0 : ot;
  assign out_last             = ol & ~areset;
  assign outstanding          = areset ? '0 : out_cnt;
  assign err                  = err_q & ~areset;
  assign dlv                  = out_valid & out_ready;
  assign s_axis_result_tready = ~areset & (~out_valid | out_ready);
  assign res_fire             = s_axis_result_tvalid & s_axis_result_tready;
  assign pop                  = res_fire & (cnt != '0);
  always_ff @(posedge aclk) begin
    if (acc) begin
      a_q     <= in_a;
      b_q     <= in_b;
      mem[wp] <= in_tag;
    end
    if (pop) begin
      od <= s_axis_result_tdata;
      ot <= mem[rp];
      ol <= frame_cnt == FRAME_END;
    end
  end
  always_ff @(posedge aclk) begin
    if (areset) begin
      a_pend    <= 1'b0;
      b_pend    <= 1'b0;
      wp        <= '0;
      rp        <= '0;
      cnt       <= '0;
      out_cnt   <= '0;
      frame_cnt <= '0;
      ov        <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      a_pend    <= acc | (a_pend & ~a_fire);
      b_pend    <= acc | (b_pend & ~b_fire);
      wp        <= acc ? wp + 1'b1 : wp;
      rp        <= pop ? rp + 1'b1 : rp;
      cnt       <= cnt + CW'(acc) - CW'(pop);
      out_cnt   <= out_cnt + CW'(acc) - CW'(dlv);
      frame_cnt <= pop ? (frame_cnt == FRAME_END ? '0 : frame_cnt + 1'b1) : frame_cnt;
      ov        <= pop | (ov & ~dlv);
      err_q     <= err_q | (res_fire & (cnt == '0));
    end
  end
endmodule

// File: tb/tb_fmul_axis_issuer.sv
// tb_fmul_axis_issuer: directed checks of issue, credit, framing, reset and backpressure against an 8-cycle core model
module tb_fmul_axis_issuer;
  logic        aclk = 0;
  logic        areset = 1;
  logic        in_valid = 0, in_ready;
  logic [31:0] in_a = 0, in_b = 0;
  logic [7:0]  in_tag = 0;
  logic        m_axis_a_tvalid, m_axis_a_tready = 1;
  logic [31:0] m_axis_a_tdata;
  logic        m_axis_b_tvalid, m_axis_b_tready = 1;
  logic [31:0] m_axis_b_tdata;
  logic        s_axis_result_tvalid = 0, s_axis_result_tready;
  logic [31:0] s_axis_result_tdata = 0;
  logic        out_valid, out_ready = 1, out_last, err;
  logic [31:0] out_data;
  logic [7:0]  out_tag;
  logic [2:0]  outstanding;
  int nvec = 0, nerr = 0, cyc = 0, acnt = 0, bcnt = 0, viol = 0;
  bit ov_seen = 0, tog = 0;
  typedef struct {int due; logic [31:0] d;} ent_t;
  ent_t pipe[$];
  logic [31:0] qa[$], qb[$], got_d[$];
  logic [7:0]  got_t[$];
  logic        got_l[$];

  fmul_axis_issuer #(.TAG_W(8), .DEPTH(4), .FRAME_LEN(4)) dut (
    .aclk(aclk), .areset(areset),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .m_axis_a_tvalid(m_axis_a_tvalid), .m_axis_a_tready(m_axis_a_tready), .m_axis_a_tdata(m_axis_a_tdata),
    .m_axis_b_tvalid(m_axis_b_tvalid), .m_axis_b_tready(m_axis_b_tready), .m_axis_b_tdata(m_axis_b_tdata),
    .s_axis_result_tvalid(s_axis_result_tvalid), .s_axis_result_tready(s_axis_result_tready),
    .s_axis_result_tdata(s_axis_result_tdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
    .out_last(out_last), .outstanding(outstanding), .err(err)
  );

  always #5 aclk = ~aclk;

  function automatic logic [31:0] fmodel(logic [31:0] a, logic [31:0] b);
    return (a == 32'h40400000 && b == 32'h40000000) ? 32'h40C00000 : a ^ b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 0;
    areset = 1;
    tick(2);
    areset = 0;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [7:0] t);
    int k = 0;
    bit ok = 0;
    in_valid = 1; in_a = a; in_b = b; in_tag = t;
    do begin
      @(posedge aclk);
      ok = in_ready;
      k++;
    end while (!ok && k < 200);
    if (!ok) chk("send_timeout", 0, 1);
    #1 in_valid = 0;
  endtask

  task automatic wait_got(input int n);
    int k = 0;
    while (got_d.size() < n && k < 1000) begin
      @(posedge aclk);
      k++;
    end
    #1;
    chk("got_count", got_d.size(), n);
  endtask

  task automatic clear_got();
    got_d.delete(); got_t.delete(); got_l.delete();
  endtask

  initial begin
    logic [31:0] a, b;
    forever begin
      @(posedge aclk);
      cyc++;
      if (m_axis_a_tvalid && m_axis_a_tready) begin qa.push_back(m_axis_a_tdata); acnt++; end
      if (m_axis_b_tvalid && m_axis_b_tready) begin qb.push_back(m_axis_b_tdata); bcnt++; end
      if (s_axis_result_tvalid && s_axis_result_tready) pipe.delete(0);
      while (qa.size() > 0 && qb.size() > 0) begin
        a = qa.pop_front();
        b = qb.pop_front();
        pipe.push_back('{cyc + 8, fmodel(a, b)});
      end
      #1;
      s_axis_result_tvalid = pipe.size() > 0 && pipe[0].due <= cyc;
      s_axis_result_tdata  = pipe.size() > 0 ? pipe[0].d : 32'h0;
    end
  end

  initial begin
    forever begin
      @(posedge aclk);
      if (out_valid) ov_seen = 1;
      if (out_valid && out_ready) begin
        got_d.push_back(out_data); got_t.push_back(out_tag); got_l.push_back(out_last);
      end
      if (!areset && s_axis_result_tready != !(out_valid && !out_ready)) viol++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // reset state
    tick(1);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_res_tready", s_axis_result_tready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_err", err, 0);
    chk("rst_a_tvalid", m_axis_a_tvalid, 0);
    tick(1);
    areset = 0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);

    // single op: 3.0 * 2.0
    clear_got();
    send(32'h40400000, 32'h40000000, 8'h05);
    chk("single_a_tvalid", m_axis_a_tvalid, 1);
    chk("single_b_tvalid", m_axis_b_tvalid, 1);
    chk("single_a_tdata", m_axis_a_tdata, 32'h40400000);
    chk("single_b_tdata", m_axis_b_tdata, 32'h40000000);
    chk("single_outstanding", outstanding, 1);
    wait_got(1);
    tick(1);
    chk("single_data", got_d[0], 32'h40C00000);
    chk("single_tag", got_t[0], 8'h05);
    chk("single_last", got_l[0], 0);
    chk("single_outstanding_end", outstanding, 0);

    // skew: b stalled 3 cycles on op 2
    do_reset();
    clear_got();
    acnt = 0; bcnt = 0;
    for (int i = 0; i < 10; i++) begin
      send(32'h3F800000 + i, 32'h40000000 + (i << 4), 8'(i));
      if (i == 2) begin
        m_axis_b_tready = 0;
        in_valid = 1; in_a = 32'h3F800003; in_b = 32'h40000030; in_tag = 8'd3;
        repeat (3) begin
          @(posedge aclk);
          chk("stall_in_ready", in_ready, 0);
        end
        #1;
        chk("stall_b_tvalid", m_axis_b_tvalid, 1);
        chk("stall_b_tdata", m_axis_b_tdata, 32'h40000020);
        m_axis_b_tready = 1;
      end
    end
    wait_got(10);
    for (int i = 0; i < 10; i++) begin
      chk("skew_tag", got_t[i], 32'(i));
      chk("skew_data", got_d[i], (32'h3F800000 + i) ^ (32'h40000000 + (i << 4)));
      chk("skew_last", got_l[i], (i % 4) == 3);
    end
    chk("skew_a_fires", acnt, 10);
    chk("skew_b_fires", bcnt, 10);

    // credit limit
    do_reset();
    clear_got();
    out_ready = 0;
    for (int i = 0; i < 4; i++) send(32'h1000 + i, 32'h2000, 8'(20 + i));
    tick(15);
    chk("credit_in_ready", in_ready, 0);
    chk("credit_outstanding", outstanding, 4);
    chk("credit_out_valid", out_valid, 1);
    out_ready = 1;
    tick(1);
    out_ready = 0;
    chk("credit_outstanding_dec", outstanding, 3);
    chk("credit_in_ready_back", in_ready, 1);
    out_ready = 1;
    wait_got(4);
    for (int i = 0; i < 4; i++) chk("credit_tag", got_t[i], 32'(20 + i));

    // frame boundary
    do_reset();
    clear_got();
    for (int i = 0; i < 9; i++) send(32'h3000 + i, 32'h55, 8'(40 + i));
    wait_got(9);
    for (int i = 0; i < 9; i++) chk("frame_last", got_l[i], (i == 3 || i == 7));

    // reset mid-flight
    do_reset();
    clear_got();
    for (int i = 0; i < 3; i++) send(32'h7000 + i, 32'h1, 8'(60 + i));
    tick(2);
    do_reset();
    ov_seen = 0;
    tick(20);
    chk("midrst_err", err, 1);
    chk("midrst_out_valid_seen", ov_seen, 0);
    chk("midrst_outstanding", outstanding, 0);
    chk("midrst_core_drained", pipe.size(), 0);
    chk("midrst_got", got_d.size(), 0);

    // output backpressure
    do_reset();
    chk("bp_err_cleared", err, 0);
    clear_got();
    viol = 0;
    tog = 1;
    fork
      while (tog) begin
        @(posedge aclk);
        #1 out_ready = ~out_ready;
      end
    join_none
    for (int i = 0; i < 20; i++) send(32'h9000 + i, 32'h0F0F0000 + i, 8'(100 + i));
    wait_got(20);
    tog = 0;
    tick(20);
    out_ready = 1;
    chk("bp_no_dup", got_d.size(), 20);
    for (int i = 0; i < 20; i++) begin
      chk("bp_tag", got_t[i], 32'(100 + i));
      chk("bp_data", got_d[i], (32'h9000 + i) ^ (32'h0F0F0000 + i));
    end
    chk("bp_tready_rule", viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/fmul_axis_issuer.md
Name: fmul_axis_issuer

Overview:
- AXI-Stream master/consumer for the floating-point multiplier core's operand and result channels.
- Drives the core's a and b operand channels from a simple upstream valid/ready operand-pair port.
- Accepts the core's result channel and re-associates each result with its upstream tag through an in-order tag FIFO.
- Bounds the number of in-flight operations with a credit counter and marks frame boundaries with out_last. Sits between FFT butterfly control and the multiplier core.

Parameters:
- TAG_W, 8, width of the upstream tag carried alongside each operation.
- DEPTH, 16, maximum operations accepted but not yet delivered on out_*; also the tag FIFO depth; power of 2, ≥2.
- FRAME_LEN, 64, results per frame; out_last is set on the final result of each frame; ≥1.

Ports:
- aclk  in  1  clock, all logic on the rising edge.
- areset  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream operand pair valid.
- in_ready  out  1  upstream operand pair ready.
- in_a  in  32  operand A, IEEE-754 single precision.
- in_b  in  32  operand B, IEEE-754 single precision.
- in_tag  in  TAG_W  tag returned with the result.
- m_axis_a_tvalid  out  1  to multiplier s_axis_a_tvalid.
- m_axis_a_tready  in  1  from multiplier s_axis_a_tready.
- m_axis_a_tdata  out  32  to multiplier s_axis_a_tdata.
- m_axis_b_tvalid  out  1  to multiplier s_axis_b_tvalid.
- m_axis_b_tready  in  1  from multiplier s_axis_b_tready.
- m_axis_b_tdata  out  32  to multiplier s_axis_b_tdata.
- s_axis_result_tvalid  in  1  from multiplier m_axis_result_tvalid.
- s_axis_result_tready  out  1  to multiplier m_axis_result_tready.
- s_axis_result_tdata  in  32  from multiplier m_axis_result_tdata.
- out_valid  out  1  result valid.
- out_ready  in  1  result ready.
- out_data  out  32  product.
- out_tag  out  TAG_W  tag of the operation that produced out_data.
- out_last  out  1  final result of the current frame.
- outstanding  out  $clog2(DEPTH+1)  operations accepted but not yet delivered on out_*.
- err  out  1  sticky flag: a result arrived while the tag FIFO was empty.

Behaviour:
- Reset: synchronous and active-high. While areset is high, every output is 0 (including in_ready and s_axis_result_tready); a_pend, b_pend, the FIFO pointers, the frame counter and err are cleared. A reset mid-operation discards all in-flight state; results returned by the core after reset are handled per the empty-FIFO rule below.
- Handshake events: a_fire = m_axis_a_tvalid & m_axis_a_tready; b_fire and res_fire are defined likewise on the b and result channels; acc = in_valid & in_ready; dlv = out_valid & out_ready.
- Issue stage:
  - On acc, register in_a and in_b into the m_axis data registers, set a_pend=1 and b_pend=1, and push in_tag into the FIFO.
  - m_axis_a_tvalid = a_pend and m_axis_b_tvalid = b_pend.
  - a_pend clears on a_fire and b_pend clears on b_fire. The two channels complete independently; a skew of any length is legal.
  - tdata stays stable while the corresponding tvalid is high.
  - in_ready = ~areset & ~(a_pend & ~a_fire) & ~(b_pend & ~b_fire) & (outstanding < DEPTH).
  - Back-to-back issue is allowed, giving 1 op/cycle when both treadys are held high.
  - Latency: acc at cycle t → both tvalids high at t+1.
- Credit counter: outstanding increments on acc and decrements on dlv. When both occur in the same cycle it is unchanged. It never exceeds DEPTH.
- Result stage:
  - s_axis_result_tready = ~areset & (~out_valid | out_ready).
  - On res_fire with the FIFO non-empty: out_data <= tdata, out_tag <= FIFO head, pop the FIFO, out_valid <= 1, out_last <= (frame_cnt == FRAME_LEN-1).
  - frame_cnt increments on each res_fire and wraps to 0 after FRAME_LEN-1.
  - out_valid clears on dlv when there is no res_fire in the same cycle.
  - Latency: res_fire at t → out_valid high at t+1.
- FIFO: push and pop in the same cycle are legal at any occupancy, including full (count unchanged).
- Empty-FIFO error: res_fire with the FIFO empty sets err=1 (sticky until reset). The result is consumed and dropped; out_valid, frame_cnt and outstanding are unaffected.
- out_* holds stable while out_valid & ~out_ready.

Test Plan:
- Single op: in_a=0x40400000 (3.0), in_b=0x40000000 (2.0), tag=0x05; multiplier model with 8-cycle latency → out_data=0x40C00000, out_tag=0x05, outstanding returns to 0.
- Skew: 10 back-to-back ops with tags 0..9; m_axis_b_tready held low for 3 cycles on op 2 → no reordering, tags delivered 0..9, each A/B pair is consumed exactly once, in_ready low during the stall.
- Credit limit with DEPTH=4 and out_ready=0: after 4 ops, in_ready=0 and outstanding=4; raise out_ready for 1 cycle → outstanding=3 and in_ready=1 the next cycle.
- Frame boundary with FRAME_LEN=4 and 9 ops → out_last=1 exactly on results 4 and 8 (1-based).
- Reset mid-flight: areset pulsed with 3 ops in flight, then the core returns 3 stale results → err=1, out_valid stays 0, outstanding=0.
- Output backpressure: out_ready toggled 1/0 every cycle over 20 ops → no result lost or duplicated; s_axis_result_tready is low only while out_valid=1 and out_ready=0.
